// File: rtl/regfile_sb.sv
// 32 x WIDTH register file with write-through bypass and a pending-destination
// scoreboard that raises stall on RAW/WAW hazards against in-flight writes.
module regfile_sb #(
    parameter int NREGS = 32,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       rd_addr1,
    input  logic [4:0]       rd_addr2,
    output logic [WIDTH-1:0] rd_data1,
    output logic [WIDTH-1:0] rd_data2,
    input  logic             wr_en,
    input  logic [4:0]       wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             issue_valid,
    input  logic [4:0]       issue_dest,
    output logic             stall,
    output logic [5:0]       pending_count
);

    logic [NREGS-1:0][WIDTH-1:0] regs;
    logic [NREGS-1:0]            pending, pending_nxt;
    logic [5:0]                  count_nxt;
    logic                        wb, hit1, hit2, hitd;
    logic                        haz1, haz2, hazd, accept;

    assign wb   = wr_en && (wr_addr != 5'd0);
    assign hit1 = wr_en && (wr_addr == rd_addr1);
    assign hit2 = wr_en && (wr_addr == rd_addr2);
    assign hitd = wr_en && (wr_addr == issue_dest);

    // A register being written back this cycle is not a hazard: the bypass
    // already hands its value to the reader.
    assign haz1   = pending[rd_addr1]   && !hit1;
    assign haz2   = pending[rd_addr2]   && !hit2;
    assign hazd   = pending[issue_dest] && !hitd;
    assign stall  = issue_valid && (haz1 || haz2 || hazd);
    assign accept = issue_valid && !stall;

    always_comb begin
        rd_data1 = '0;
        if (rd_addr1 != 5'd0)
            rd_data1 = hit1 ? wr_data : regs[rd_addr1];
    end

    always_comb begin
        rd_data2 = '0;
        if (rd_addr2 != 5'd0)
            rd_data2 = hit2 ? wr_data : regs[rd_addr2];
    end

    // Clear before set so a same-cycle issue to the written register wins.
    always_comb begin
        pending_nxt = pending;
        if (wb)
            pending_nxt[wr_addr] = 1'b0;
        if (accept && (issue_dest != 5'd0))
            pending_nxt[issue_dest] = 1'b1;
        pending_nxt[0] = 1'b0;
    end

    always_comb begin
        count_nxt = '0;
        for (int i = 0; i < NREGS; i++)
            count_nxt = count_nxt + 6'(pending_nxt[i]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            regs          <= '0;
            pending       <= '0;
            pending_count <= '0;
        end else begin
            if (wb)
                regs[wr_addr] <= wr_data;
            pending       <= pending_nxt;
            pending_count <= count_nxt;
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: storage, bypass, scoreboard hazards, reset.
module tb_regfile_sb;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  rd_addr1, rd_addr2, wr_addr, issue_dest;
    logic [31:0] rd_data1, rd_data2, wr_data;
    logic        wr_en, issue_valid, stall;
    logic [5:0]  pending_count;

    int errors = 0;
    int checks = 0;

    regfile_sb #(.NREGS(32), .WIDTH(32)) dut (
        .clk(clk), .reset(reset),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_data1(rd_data1), .rd_data2(rd_data2),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .issue_valid(issue_valid), .issue_dest(issue_dest),
        .stall(stall), .pending_count(pending_count)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        wr_en = 0; wr_addr = 0; wr_data = 0;
        issue_valid = 0; issue_dest = 0;
        rd_addr1 = 0; rd_addr2 = 0;
    endtask

    task automatic do_reset;
        reset = 1; tick(); tick(); reset = 0;
    endtask

    task automatic test_reset;
        idle(); do_reset();
        checks++;
        if (pending_count !== 6'd0) begin
            errors++; $display("FAIL reset_count: got %0d exp 0", pending_count);
        end
        for (int i = 0; i < 32; i++) begin
            rd_addr1 = 5'(i); rd_addr2 = 5'(31 - i); #1;
            checks++;
            if (rd_data1 !== 32'd0 || rd_data2 !== 32'd0) begin
                errors++; $display("FAIL reset_read r%0d: got %h/%h exp 0", i, rd_data1, rd_data2);
            end
        end
        issue_valid = 1; issue_dest = 3; rd_addr1 = 5; rd_addr2 = 9; #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++; $display("FAIL reset_stall: got %b exp 0", stall);
        end
        idle();
    endtask

    task automatic test_write_read;
        wr_en = 1; wr_addr = 5; wr_data = 32'hDEADBEEF; tick();
        idle(); rd_addr1 = 5; rd_addr2 = 5; #1;
        checks++;
        if (rd_data1 !== 32'hDEADBEEF || rd_data2 !== 32'hDEADBEEF) begin
            errors++; $display("FAIL wr_r5: got %h/%h exp deadbeef", rd_data1, rd_data2);
        end
        wr_en = 1; wr_addr = 0; wr_data = 32'h1234; rd_addr1 = 0; #1;
        checks++;
        if (rd_data1 !== 32'd0) begin
            errors++; $display("FAIL r0_bypass: got %h exp 0", rd_data1);
        end
        tick(); idle(); #1;
        checks++;
        if (rd_data1 !== 32'd0 || pending_count !== 6'd0) begin
            errors++; $display("FAIL r0_write: got %h cnt %0d exp 0 cnt 0", rd_data1, pending_count);
        end
    endtask

    task automatic test_bypass;
        wr_en = 1; wr_addr = 7; wr_data = 32'hA5A5A5A5; rd_addr1 = 7; #1;
        checks++;
        if (rd_data1 !== 32'hA5A5A5A5) begin
            errors++; $display("FAIL bypass: got %h exp a5a5a5a5", rd_data1);
        end
        tick(); idle(); rd_addr1 = 7; #1;
        checks++;
        if (rd_data1 !== 32'hA5A5A5A5 || pending_count !== 6'd0) begin
            errors++; $display("FAIL nonpending_wb: got %h cnt %0d exp a5a5a5a5 cnt 0", rd_data1, pending_count);
        end
    endtask

    task automatic test_raw;
        issue_valid = 1; issue_dest = 3; #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++; $display("FAIL raw_first_issue: got %b exp 0", stall);
        end
        tick();
        issue_valid = 1; issue_dest = 10; rd_addr2 = 3; #1;
        checks++;
        if (stall !== 1'b1 || pending_count !== 6'd1) begin
            errors++; $display("FAIL raw_stall: got %b cnt %0d exp 1 cnt 1", stall, pending_count);
        end
        wr_en = 1; wr_addr = 3; wr_data = 32'hCAFE0003; #1;
        checks++;
        if (stall !== 1'b0 || rd_data2 !== 32'hCAFE0003) begin
            errors++; $display("FAIL raw_bypass: got %b %h exp 0 cafe0003", stall, rd_data2);
        end
        tick(); idle();
        checks++;
        if (pending_count !== 6'd1) begin
            errors++; $display("FAIL raw_swap_count: got %0d exp 1", pending_count);
        end
        wr_en = 1; wr_addr = 10; wr_data = 32'h10; tick(); idle();
        checks++;
        if (pending_count !== 6'd0) begin
            errors++; $display("FAIL raw_drain: got %0d exp 0", pending_count);
        end
    endtask

    task automatic test_waw;
        issue_valid = 1; issue_dest = 9; tick();
        issue_valid = 1; issue_dest = 9; #1;
        checks++;
        if (stall !== 1'b1) begin
            errors++; $display("FAIL waw_stall: got %b exp 1", stall);
        end
        tick();
        checks++;
        if (pending_count !== 6'd1) begin
            errors++; $display("FAIL waw_hold_count: got %0d exp 1", pending_count);
        end
        wr_en = 1; wr_addr = 9; wr_data = 32'h99; #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++; $display("FAIL waw_wb_unstall: got %b exp 0", stall);
        end
        tick(); idle();
        checks++;
        if (pending_count !== 6'd1) begin
            errors++; $display("FAIL waw_set_wins_count: got %0d exp 1", pending_count);
        end
        issue_valid = 1; issue_dest = 9; #1;
        checks++;
        if (stall !== 1'b1) begin
            errors++; $display("FAIL waw_set_wins: got %b exp 1", stall);
        end
        idle(); wr_en = 1; wr_addr = 9; tick(); idle();
    endtask

    task automatic test_fill;
        for (int i = 1; i < 32; i++) begin
            issue_valid = 1; issue_dest = 5'(i); tick();
            if (i == 16) begin
                checks++;
                if (pending_count !== 6'd16) begin
                    errors++; $display("FAIL fill_half: got %0d exp 16", pending_count);
                end
            end
        end
        idle();
        checks++;
        if (pending_count !== 6'd31) begin
            errors++; $display("FAIL fill_full: got %0d exp 31", pending_count);
        end
        issue_valid = 1; issue_dest = 0; #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++; $display("FAIL r0_no_stall: got %b exp 0", stall);
        end
        tick();
        checks++;
        if (pending_count !== 6'd31) begin
            errors++; $display("FAIL r0_no_pending: got %0d exp 31", pending_count);
        end
        rd_addr1 = 5; #1;
        checks++;
        if (stall !== 1'b1) begin
            errors++; $display("FAIL full_src_stall: got %b exp 1", stall);
        end
        idle();
    endtask

    task automatic test_reset_mid;
        do_reset();
        wr_en = 1; wr_addr = 4; wr_data = 32'h55; tick(); idle();
        issue_valid = 1; issue_dest = 4; tick();
        issue_valid = 1; issue_dest = 6; tick(); idle();
        rd_addr1 = 4; #1;
        checks++;
        if (pending_count !== 6'd2 || rd_data1 !== 32'h55) begin
            errors++; $display("FAIL mid_setup: got cnt %0d %h exp cnt 2 55", pending_count, rd_data1);
        end
        reset = 1; wr_en = 1; wr_addr = 8; wr_data = 32'h88;
        issue_valid = 1; issue_dest = 7; tick();
        reset = 0; idle(); rd_addr1 = 4; rd_addr2 = 8; #1;
        checks++;
        if (pending_count !== 6'd0 || rd_data1 !== 32'd0 || rd_data2 !== 32'd0) begin
            errors++; $display("FAIL mid_reset: got cnt %0d %h %h exp cnt 0 0 0", pending_count, rd_data1, rd_data2);
        end
        issue_valid = 1; issue_dest = 6; rd_addr1 = 4; #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++; $display("FAIL mid_reset_stall: got %b exp 0", stall);
        end
        idle(); wr_en = 1; wr_addr = 4; wr_data = 32'h77; tick(); idle();
        rd_addr1 = 4; #1;
        checks++;
        if (pending_count !== 6'd0 || rd_data1 !== 32'h77) begin
            errors++; $display("FAIL stale_wb: got cnt %0d %h exp cnt 0 77", pending_count, rd_data1);
        end
    endtask

    initial begin
        reset = 1; idle();
        test_reset();
        test_write_read();
        test_bypass();
        test_raw();
        test_waw();
        test_fill();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 The block SHALL have parameter NREGS, default 32, meaning the number of architectural registers (fixed at 32; 5-bit addresses).
REQ-002 The block SHALL have parameter WIDTH, default 32, meaning the data width of each register.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port rd_addr1, input, 5 bits: read port 1 address.
REQ-006 The block SHALL have port rd_addr2, input, 5 bits: read port 2 address.
REQ-007 The block SHALL have port rd_data1, output, 32 bits: read port 1 data.
REQ-008 The block SHALL have port rd_data2, output, 32 bits: read port 2 data.
REQ-009 The block SHALL have port wr_en, input, 1 bit: write-back strobe.
REQ-010 The block SHALL have port wr_addr, input, 5 bits: write-back destination.
REQ-011 The block SHALL have port wr_data, input, 32 bits: write-back data.
REQ-012 The block SHALL have port issue_valid, input, 1 bit: an instruction requests issue this cycle.
REQ-013 The block SHALL have port issue_dest, input, 5 bits: destination of the issuing instruction.
REQ-014 The block SHALL have port stall, output, 1 bit: issue blocked this cycle.
REQ-015 The block SHALL have port pending_count, output, 6 bits: registered count of pending destinations.

Function
REQ-016 The block SHALL hold 32 x 32-bit registers; register 0 SHALL always read 0, and writes to it SHALL be ignored.
REQ-017 The block SHALL write wr_data to register wr_addr on the rising clk edge when wr_en=1, wr_addr!=0 and reset=0.
REQ-018 Each read port SHALL be combinational: rd_dataN = 0 if rd_addrN=0; else wr_data if wr_en=1 and wr_addr=rd_addrN (write-through bypass); else the stored value.
REQ-019 The block SHALL keep a 32-bit pending vector; bit 0 SHALL be constant 0.
REQ-020 Issue accept = issue_valid & !stall; on accept with issue_dest!=0, pending[issue_dest] SHALL be set at the next edge.
REQ-021 wr_en=1 with wr_addr!=0 SHALL clear pending[wr_addr] at the next edge.
REQ-022 When an accepted issue and a write-back target the same register in one cycle, the set SHALL win (pending stays 1).
REQ-023 A source is hazardous iff pending[rd_addrN]=1 and NOT (wr_en=1 and wr_addr=rd_addrN), since the bypass supplies the value.
REQ-024 Destination is hazardous (WAW) iff pending[issue_dest]=1 and NOT (wr_en=1 and wr_addr=issue_dest).
REQ-025 stall SHALL be combinational: issue_valid & (hazard on rd_addr1 | hazard on rd_addr2 | destination hazard); stall=0 when issue_valid=0.
REQ-026 pending_count SHALL equal the population count of the pending vector after each edge (range 0-31, never wraps).
REQ-027 Write-back to a non-pending register SHALL be legal: data written, pending unchanged.

Reset
REQ-028 With reset=1 at a rising edge, all 32 registers SHALL become 0, pending SHALL become all-zero and pending_count 0; reset SHALL override any simultaneous write or issue.
REQ-029 Reset asserted mid-operation SHALL discard all outstanding pending bits; the write-back of a discarded destination after reset SHALL write data and leave pending clear.
REQ-030 After reset, rd_data1/rd_data2 SHALL read 0 for every address absent bypass, and stall SHALL be 0.

Verification
REQ-031 Reset, then write 0xDEADBEEF to r5, next cycle read r5 on both ports -> both = 0xDEADBEEF; write 0x1234 to r0 -> r0 reads 0.
REQ-032 wr_en=1, wr_addr=7, wr_data=0xA5A5A5A5, rd_addr1=7 same cycle -> rd_data1=0xA5A5A5A5 before the edge.
REQ-033 Issue dest r3 (accepted), next cycle issue_valid with rd_addr2=3 and no write-back -> stall=1, pending_count=1; write-back r3 that cycle -> stall=0, rd_data2=wr_data.
REQ-034 Pending r9, issue dest r9 -> stall=1 (WAW); same-cycle write-back r9 plus accepted issue dest r9 -> pending[9] remains 1, pending_count unchanged.
REQ-035 Issue dests r1..r31 over 31 cycles with no write-back -> pending_count=31; issue dest r0 -> never sets pending, no stall from r0 sources.
REQ-036 Pending r4 and r6, r4 holding 0x55, assert reset one cycle -> pending_count=0, r4 reads 0, issue with rd_addr1=4 -> stall=0.
